// File: rtl/led_sequencer.sv
// LED bank sequencer: prescaled step tick drives an OFF/COUNT/CHASE/BLINK pattern
// FSM, configuration is staged and applied on tick boundaries, and a PWM stage dims the drive.
module led_sequencer #(
  parameter int PRESCALE_W = 25,
  parameter int PWM_W      = 4,
  parameter int LED_W      = 4
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Cfg_valid_i,
  output logic             Cfg_ready_o,
  input  logic [1:0]       Cfg_mode_i,
  input  logic [LED_W-1:0] Cfg_pattern_i,
  input  logic [PWM_W-1:0] Cfg_duty_i,
  output logic [LED_W-1:0] Led_o,
  output logic             Tick_o,
  output logic [1:0]       Mode_o
);

  typedef enum logic [1:0] {
    M_OFF   = 2'b00,
    M_COUNT = 2'b01,
    M_CHASE = 2'b10,
    M_BLINK = 2'b11
  } mode_e;

  localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]      pwm_q, pwm_d, duty_q, duty_d, pend_duty_q, pend_duty_d;
  logic [LED_W-1:0]      pat_q, pat_d, pend_pat_q, pend_pat_d, led_q, led_d;
  mode_e                 mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic                  phase_q, phase_d, pending_q, pending_d, tick_q;
  logic                  tick, accept, pwm_on;

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      presc_q     <= '0;
      pwm_q       <= '0;
      tick_q      <= 1'b0;
      led_q       <= '0;
      mode_q      <= M_OFF;
      pat_q       <= '0;
      phase_q     <= 1'b0;
      duty_q      <= '1;
      pending_q   <= 1'b0;
      pend_mode_q <= M_OFF;
      pend_pat_q  <= '0;
      pend_duty_q <= '0;
    end else begin
      presc_q     <= presc_d;
      pwm_q       <= pwm_d;
      tick_q      <= tick;
      led_q       <= led_d;
      mode_q      <= mode_d;
      pat_q       <= pat_d;
      phase_q     <= phase_d;
      duty_q      <= duty_d;
      pending_q   <= pending_d;
      pend_mode_q <= pend_mode_d;
      pend_pat_q  <= pend_pat_d;
      pend_duty_q <= pend_duty_d;
    end
  end

  always_comb begin
    tick        = &presc_q;
    accept      = Cfg_valid_i && !pending_q;
    pwm_on      = (duty_q == '1) || (pwm_q < duty_q);
    presc_d     = presc_q + PRESCALE_W'(1);
    pwm_d       = pwm_q + PWM_W'(1);
    mode_d      = mode_q;
    pat_d       = pat_q;
    phase_d     = phase_q;
    duty_d      = duty_q;
    pending_d   = pending_q;
    pend_mode_d = pend_mode_q;
    pend_pat_d  = pend_pat_q;
    pend_duty_d = pend_duty_q;

    // A staged config takes the whole tick; the pattern does not also step.
    if (tick && pending_q) begin
      mode_d    = pend_mode_q;
      duty_d    = pend_duty_q;
      phase_d   = 1'b1;
      pending_d = 1'b0;
      case (pend_mode_q)
        M_CHASE: pat_d = (pend_pat_q == '0) ? LED_ONE : pend_pat_q;
        M_BLINK: pat_d = pend_pat_q;
        default: pat_d = '0;
      endcase
    end else if (tick) begin
      case (mode_q)
        M_COUNT: pat_d   = pat_q + LED_ONE;
        M_CHASE: pat_d   = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        M_BLINK: phase_d = !phase_q;
        default: pat_d   = pat_q;
      endcase
    end

    if (accept) begin
      pending_d   = 1'b1;
      pend_mode_d = mode_e'(Cfg_mode_i);
      pend_pat_d  = Cfg_pattern_i;
      pend_duty_d = Cfg_duty_i;
    end

    led_d = '0;
    if (pwm_on && (mode_q != M_OFF) && !((mode_q == M_BLINK) && !phase_q))
      led_d = pat_q;
  end

  assign Cfg_ready_o = !pending_q;
  assign Led_o       = led_q;
  assign Tick_o      = tick_q;
  assign Mode_o      = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized and directed stimulus for led_sequencer, checked cycle by cycle
// against an arithmetic reference model through an expected-value queue.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [1:0] mode_in = 2'd0;
  logic [3:0] pat_in = 4'd0;
  logic [3:0] duty_in = 4'd0;
  logic       Cfg_ready_o, Tick_o;
  logic [3:0] Led_o;
  logic [1:0] Mode_o;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] led;
    logic       tick;
    logic [1:0] mode;
    logic       ready;
  } exp_t;

  exp_t q[$];
  exp_t mon_e, mon_a, m_e;

  led_sequencer #(.PRESCALE_W(3), .PWM_W(4), .LED_W(4)) dut (
    .Clk_i(clk), .Rst_i(rst), .Cfg_valid_i(vld), .Cfg_ready_o(Cfg_ready_o),
    .Cfg_mode_i(mode_in), .Cfg_pattern_i(pat_in), .Cfg_duty_i(duty_in),
    .Led_o(Led_o), .Tick_o(Tick_o), .Mode_o(Mode_o)
  );

  always #5 clk = ~clk;

  // Reference model: time is a cycle count since reset; tick and PWM follow from it.
  int         m_cnt;
  logic [1:0] m_mode, p_mode;
  logic [3:0] m_pat, m_duty, p_pat, p_duty, m_vis;
  bit         m_phase, m_pend, m_tick, m_on, m_acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_mode = 0; m_pat = 0; m_phase = 0; m_duty = 15; m_pend = 0;
      q.delete();
    end else begin
      m_tick = (m_cnt % 8) == 7;
      m_on   = (m_duty == 15) || ((m_cnt % 16) < m_duty);
      m_vis  = (m_mode == 0 || (m_mode == 3 && !m_phase)) ? 4'd0 : m_pat;
      m_e.led  = m_on ? m_vis : 4'd0;
      m_e.tick = m_tick;
      m_acc = vld && !m_pend;
      if (m_tick && m_pend) begin
        m_mode = p_mode; m_duty = p_duty; m_phase = 1; m_pend = 0;
        if (p_mode == 2) m_pat = (p_pat == 0) ? 4'd1 : p_pat;
        else if (p_mode == 3) m_pat = p_pat;
        else m_pat = 0;
        $display("apply mode=%0d pat=%b duty=%0d at cycle %0d", m_mode, m_pat, m_duty, m_cnt);
      end else if (m_tick) begin
        if (m_mode == 1) m_pat = 4'((m_pat + 1) % 16);
        else if (m_mode == 2) m_pat = 4'(((m_pat * 2) % 16) + (m_pat / 8));
        else if (m_mode == 3) m_phase = !m_phase;
      end
      if (m_acc) begin
        m_pend = 1; p_mode = mode_in; p_pat = pat_in; p_duty = duty_in;
      end
      m_cnt++;
      m_e.mode  = m_mode;
      m_e.ready = !m_pend;
      q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = {Led_o, Tick_o, Mode_o, Cfg_ready_o};
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL cycle_check t=%0t got led=%b tick=%b mode=%0d ready=%b want led=%b tick=%b mode=%0d ready=%b",
                 $time, mon_a.led, mon_a.tick, mon_a.mode, mon_a.ready,
                 mon_e.led, mon_e.tick, mon_e.mode, mon_e.ready);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Called one time unit after a rising edge; holds valid for exactly the accepting edge.
  task automatic send_cfg(input logic [1:0] m, input logic [3:0] p, input logic [3:0] d);
    int budget = 0;
    while (!Cfg_ready_o && budget < 100) begin
      @(posedge clk); #1; budget++;
    end
    if (!Cfg_ready_o) begin
      total++; bad++;
      $display("FAIL ready_timeout got=%b want=1", Cfg_ready_o);
    end
    vld = 1'b1; mode_in = m; pat_in = p; duty_in = d;
    @(posedge clk); #1;
    vld = 1'b0;
    $display("cfg sent mode=%0d pat=%b duty=%0d", m, p, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", {Led_o, Tick_o, Mode_o, Cfg_ready_o}, {4'd0, 1'b0, 2'd0, 1'b1});
    run(20);

    send_cfg(2'd1, 4'd0, 4'hF);
    run(16 * 8 + 12);

    send_cfg(2'd2, 4'b0000, 4'hF);
    run(6 * 8);
    send_cfg(2'd2, 4'b1001, 4'hF);
    run(3 * 8);

    send_cfg(2'd3, 4'b1010, 4'h4);
    run(6 * 8);
    send_cfg(2'd3, 4'b1010, 4'h0);
    run(4 * 8);

    // Accept lands on the tick edge; a second request is held while not ready.
    b = 0;
    while (!Tick_o && b < 20) begin @(posedge clk); #1; b++; end
    check("tick_seen", {7'd0, Tick_o}, 8'd1);
    repeat (7) @(posedge clk);
    #1;
    vld = 1'b1; mode_in = 2'd2; pat_in = 4'b0110; duty_in = 4'hF;
    @(posedge clk); #1;
    $display("cfg sent on tick mode=2 pat=0110 duty=15");
    mode_in = 2'd1; pat_in = 4'b0011; duty_in = 4'h7;
    run(5);
    vld = 1'b0;
    run(20);
    check("first_cfg_wins", {6'd0, Mode_o}, 8'd2);

    for (int i = 0; i < 12; i++) begin
      send_cfg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      run($urandom_range(8, 40));
    end

    send_cfg(2'd1, 4'd0, 4'hF);
    run(40);
    send_cfg(2'd2, 4'b0101, 4'hF);
    check("pending_ready_low", {7'd0, Cfg_ready_o}, 8'd0);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {Led_o, Tick_o, Mode_o, Cfg_ready_o}, {4'd0, 1'b0, 2'd0, 1'b1});
    @(posedge clk); #1;
    rst = 1'b0;
    run(40);
    check("pending_discarded", {6'd0, Mode_o}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
